wb_multi_commit: RTL
====================

WB_MULTI_COMMIT -- requirements
Module: wb_multi_commit

Interface
REQ-001 Parameter NUM_PORTS, default 3: number of writeback source channels (ALU, LSU, MUL); legal range 1..8.
REQ-002 Parameter DATA_W, default 32: register data and PC width.
REQ-003 Parameter RF_ADDR_W, default 5: register file address width.
REQ-004 Parameter CAUSE_W, default 4: exception cause code width.
REQ-005 Parameter FLUSH_CYCLES, default 2: length of the post-trap flush window; legal range 1..15.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst_i  input  1  synchronous active-high reset.
REQ-009 wb_valid_i  input  NUM_PORTS  per-port writeback request.
REQ-010 wb_ready_o  output  NUM_PORTS  per-port grant; a transfer occurs on port p when wb_valid_i[p] and wb_ready_o[p] are both high.
REQ-011 wb_rd_we_i  input  NUM_PORTS  per-port destination-write intent.
REQ-012 wb_rd_addr_i  input  NUM_PORTS*RF_ADDR_W  packed destination addresses; port p occupies slice p.
REQ-013 wb_rd_data_i  input  NUM_PORTS*DATA_W  packed result data.
REQ-014 wb_pc_i  input  NUM_PORTS*DATA_W  packed instruction PCs.
REQ-015 wb_exc_i  input  NUM_PORTS  per-port exception flag.
REQ-016 wb_cause_i  input  NUM_PORTS*CAUSE_W  packed exception causes.
REQ-017 rf_we_o / rf_waddr_o / rf_wdata_o  output  1 / RF_ADDR_W / DATA_W  register file write port.
REQ-018 retire_o  output  1  one-cycle pulse per committed non-excepting instruction.
REQ-019 trap_o / trap_cause_o / trap_pc_o  output  1 / CAUSE_W / DATA_W  trap request to the CSR unit.
REQ-020 flush_o  output  1  pipeline flush request.

Function
REQ-021 The FSM SHALL have three states: RUN, TRAP and FLUSH; reset state is RUN.
REQ-022 In RUN, exactly one valid port SHALL receive wb_ready_o, chosen round-robin starting from the priority pointer; in TRAP and FLUSH all wb_ready_o SHALL be low.
REQ-023 wb_ready_o SHALL be combinational from wb_valid_i and the pointer; with no valid port, all ready bits SHALL be low.
REQ-024 After a transfer on port p, the pointer SHALL become (p+1) mod NUM_PORTS; with no transfer, the pointer SHALL hold.
REQ-025 Outputs SHALL be registered, with latency exactly 1 cycle from the transfer edge.
REQ-026 Transfer without exception: the next cycle SHALL show rf_we_o = rd_we & (rd_addr != 0), rf_waddr_o = rd_addr, rf_wdata_o = rd_data, and retire_o = 1.
REQ-027 A write to x0 SHALL still pulse retire_o; rf_we_o SHALL stay 0.
REQ-028 Transfer with exception: the FSM SHALL go RUN->TRAP; in the TRAP cycle, trap_o = 1, trap_cause_o/trap_pc_o carry the port's cause/PC, and rf_we_o = retire_o = 0.
REQ-029 flush_o SHALL be high in the TRAP cycle and in every FLUSH cycle.
REQ-030 TRAP SHALL last 1 cycle, then go to FLUSH; FLUSH SHALL last FLUSH_CYCLES cycles (internal counter), then return to RUN.
REQ-031 On the first RUN cycle after FLUSH, grants SHALL resume from the pointer value set by the excepting transfer.
REQ-032 Cycles without a transfer SHALL drive rf_we_o, retire_o and trap_o to 0; data outputs SHALL be 0 when their strobe is low.
REQ-033 Sources SHALL hold their payload stable while valid and not ready; the bench SHALL check this with an assertion.

Reset
REQ-034 While rst_i is high at a clock edge, the block SHALL set state=RUN, pointer=0, flush counter=0, and all outputs to 0 on that edge.
REQ-035 Reset asserted during TRAP or FLUSH SHALL abort the sequence; a pending commit SHALL be dropped with no rf_we_o or trap_o afterwards.
REQ-036 While rst_i is high, wb_ready_o SHALL be all 0.

Verification
REQ-037 Ports 0,1,2 valid continuously, rd_we=1, addrs 1,2,3 -> grants 0,1,2,0...; rf_waddr_o 1,2,3 one cycle after each grant; retire_o high every cycle.
REQ-038 Port 1 only, addr 0, data 0xDEADBEEF -> retire_o=1, rf_we_o=0 one cycle later.
REQ-039 Port 2 exception, cause 4'h5, pc 0x100, FLUSH_CYCLES=2 -> next cycle trap_o=1, trap_cause_o=5, trap_pc_o=0x100; flush_o high 3 cycles; ready low 3 cycles; then port 0 granted first.
REQ-040 Port 0 valid with exception and port 1 valid clean in the same cycle, pointer=0 -> port 0 traps; port 1 is not granted until RUN resumes, then commits.
REQ-041 rst_i pulsed in the second FLUSH cycle -> all outputs 0 on the next edge; grant pointer 0; normal commits resume on the following cycle.
REQ-042 Port 1 held valid while port 0 is granted -> port 1 payload unchanged until its grant; committed value matches the held data.

Source files
------------

// File: rtl/wb_multi_commit.sv
// wb_multi_commit: round-robin writeback commit with trap/flush sequencing; ports: wb_* per-source requests in, rf_* register write, retire_o, trap_*, flush_o out
module wb_multi_commit #(
  parameter int NUM_PORTS    = 3,
  parameter int DATA_W       = 32,
  parameter int RF_ADDR_W    = 5,
  parameter int CAUSE_W      = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_PORTS-1:0]           wb_valid_i,
  output logic [NUM_PORTS-1:0]           wb_ready_o,
  input  logic [NUM_PORTS-1:0]           wb_rd_we_i,
  input  logic [NUM_PORTS*RF_ADDR_W-1:0] wb_rd_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]    wb_rd_data_i,
  input  logic [NUM_PORTS*DATA_W-1:0]    wb_pc_i,
  input  logic [NUM_PORTS-1:0]           wb_exc_i,
  input  logic [NUM_PORTS*CAUSE_W-1:0]   wb_cause_i,
  output logic                           rf_we_o,
  output logic [RF_ADDR_W-1:0]           rf_waddr_o,
  output logic [DATA_W-1:0]              rf_wdata_o,
  output logic                           retire_o,
  output logic                           trap_o,
  output logic [CAUSE_W-1:0]             trap_cause_o,
  output logic [DATA_W-1:0]              trap_pc_o,
  output logic                           flush_o
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  typedef enum logic [1:0] {RUN, TRAP, FLUSH} state_e;
  state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, sel;
  logic [PW:0] k;
  logic [3:0] cnt_q, cnt_d;
  logic found, grant, p_exc, wr;
  logic [RF_ADDR_W-1:0] p_addr, rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] p_data, rf_wdata_q, rf_wdata_d, tpc_q, tpc_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic rf_we_q, rf_we_d, retire_q, retire_d, trap_q, trap_d;
  always_comb begin
    found = 1'b0;
    sel = '0;
    k = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      k = {1'b0, ptr_q} + (PW+1)'(i);
      k = k >= (PW+1)'(NUM_PORTS) ? k - (PW+1)'(NUM_PORTS) : k;
      if (!found && wb_valid_i[k[PW-1:0]]) begin
        found = 1'b1;
        sel = k[PW-1:0];
      end
    end
    grant = found && state_q == RUN && !rst_i;
    wb_ready_o = '0;
    wb_ready_o[sel] = grant;
    p_exc = wb_exc_i[sel];
    p_addr = wb_rd_addr_i[sel*RF_ADDR_W +: RF_ADDR_W];
    p_data = wb_rd_data_i[sel*DATA_W +: DATA_W];
    wr = grant && !p_exc && wb_rd_we_i[sel] && p_addr != '0;
    rf_we_d = wr;
    rf_waddr_d = wr ? p_addr : '0;
    rf_wdata_d = wr ? p_data : '0;
    retire_d = grant && !p_exc;
    trap_d = grant && p_exc;
    cause_d = trap_d ? wb_cause_i[sel*CAUSE_W +: CAUSE_W] : '0;
    tpc_d = trap_d ? wb_pc_i[sel*DATA_W +: DATA_W] : '0;
    ptr_d = grant ? (sel == PW'(NUM_PORTS-1) ? '0 : sel + 1'b1) : ptr_q;
    state_d = state_q;
    cnt_d = cnt_q;
    if (trap_d) state_d = TRAP;
    else if (state_q == TRAP) begin
      state_d = FLUSH;
      cnt_d = 4'(FLUSH_CYCLES - 1);
    end else if (state_q == FLUSH) begin
      state_d = cnt_q == '0 ? RUN : FLUSH;
      cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      ptr_q <= '0;
      cnt_q <= '0;
      rf_we_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      retire_q <= 1'b0;
      trap_q <= 1'b0;
      cause_q <= '0;
      tpc_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      rf_we_q <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      retire_q <= retire_d;
      trap_q <= trap_d;
      cause_q <= cause_d;
      tpc_q <= tpc_d;
    end
  end
  assign rf_we_o = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign retire_o = retire_q;
  assign trap_o = trap_q;
  assign trap_cause_o = cause_q;
  assign trap_pc_o = tpc_q;
  assign flush_o = state_q != RUN;
endmodule
